// File: rtl/stretch_sched_pkg.sv
// stretch_sched_pkg: scheduler state encodings and a constant clog2 helper.
package stretch_sched_pkg;

    // 2'd3 cannot be reached; the scheduler treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/stretch_sched_if.sv
// stretch_sched_if: requester strobes in, stretched pulse and status out.
interface stretch_sched_if #(parameter int N = 4);

    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           stb;
    logic [IDW-1:0] id;
    logic [N-1:0]   pend;
    logic [N-1:0]   drop;
    logic           busy;

    // master is the scheduler, slave is the requester/consumer side.
    modport master (input req, output stb, output id, output pend, output drop, output busy);
    modport slave  (output req, input stb, input id, input pend, input drop, input busy);

endinterface

// File: rtl/stretch_sched_rr_pick.sv
// stretch_sched_rr_pick: first set bit at or after ptr, wrapping modulo N.
module stretch_sched_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] win
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0] j;

    // Scan from the farthest offset down so the nearest set bit wins last.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % N);
            if (vec[j]) begin
                valid = 1'b1;
                win   = j;
            end
        end
    end

endmodule

// File: rtl/stretch_sched.sv
// stretch_sched: round-robin sharing of one stretched-pulse channel among N requesters.
module stretch_sched
    import stretch_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int STRETCH = 2,
    parameter int GAP     = 2
) (
    input logic            clk,
    input logic            reset_n,
    stretch_sched_if.master bus
);

    localparam int IDW = $clog2(N);
    localparam int CW  = clog2(STRETCH > GAP ? STRETCH : GAP) + 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] ptr, id, win;
    logic [N-1:0]   pend, drop, cand, clr, pend_n, drop_n;
    logic           stb, valid, grant, in_idle;

    assign in_idle = state != HIGH && state != LOW;
    // At the end of LOW an event arriving this cycle can be granted directly.
    assign cand    = state == LOW ? pend | bus.req : pend;
    assign grant   = valid && (in_idle || (state == LOW && cnt == '0));
    assign clr     = grant ? N'(1) << win : '0;
    // A granted bit keeps a coincident req only if it was already pending; otherwise that req is the grant.
    assign pend_n  = (pend & ~clr) | (bus.req & ~(clr & ~pend));
    assign drop_n  = bus.req & pend & ~clr;

    stretch_sched_rr_pick #(.N(N)) u_pick (
        .vec  (cand),
        .ptr  (ptr),
        .valid(valid),
        .win  (win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            stb   <= 1'b0;
            id    <= '0;
            ptr   <= '0;
            cnt   <= '0;
            pend  <= '0;
            drop  <= '0;
        end else begin
            pend <= pend_n;
            drop <= drop_n;
            if (grant) begin
                state <= HIGH;
                stb   <= 1'b1;
                id    <= win;
                ptr   <= win == IDW'(N - 1) ? '0 : win + 1'b1;
                cnt   <= CW'(STRETCH - 1);
            end else begin
                case (state)
                    HIGH: begin
                        if (cnt == '0) begin
                            state <= LOW;
                            stb   <= 1'b0;
                            cnt   <= CW'(GAP - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt == '0) state <= IDLE;
                        else cnt <= cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.stb  = stb;
    assign bus.id   = id;
    assign bus.pend = pend;
    assign bus.drop = drop;
    assign bus.busy = !in_idle;

endmodule

// File: tb/tb_stretch_sched.sv
// tb_stretch_sched: directed scenarios with a pulse scoreboard checked by a separate monitor.
module tb_stretch_sched;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   c0 = 0;
    int   seen = 0;
    logic stb_q = 1'b0;
    exp_t q[$];

    stretch_sched_if #(.N(4)) bus ();

    stretch_sched #(.N(4), .STRETCH(2), .GAP(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc - c0);
        end
    endtask

    // Each rising edge of stb must match the oldest expected pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.stb && !stb_q) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse: unexpected pulse id=%0d at cycle %0d, required none", bus.id, cyc - c0);
            end else begin
                e = q.pop_front();
                chk("pulse_id", int'(bus.id), e.id);
                chk("pulse_cycle", cyc - c0, e.cyc - c0);
            end
        end
        stb_q = bus.stb;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic to_cycle(input int t);
        while (cyc - c0 < t) step();
    endtask

    task automatic push(input int id, input int t);
        exp_t e;
        e.id  = id;
        e.cyc = c0 + t;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        c0 = cyc;
    endtask

    initial begin
        bus.req = '0;
        step();
        step();
        chk("reset_stb", int'(bus.stb), 0);
        chk("reset_id", int'(bus.id), 0);
        chk("reset_pend", int'(bus.pend), 0);
        chk("reset_drop", int'(bus.drop), 0);
        chk("reset_busy", int'(bus.busy), 0);

        // 1: single request on bit 2
        do_reset();
        push(2, 2);
        bus.req = 4'b0100;
        step();
        bus.req = '0;
        chk("t1_pend_c1", int'(bus.pend), 4);
        chk("t1_stb_c1", int'(bus.stb), 0);
        to_cycle(2);
        chk("t1_pend_c2", int'(bus.pend), 0);
        chk("t1_stb_c2", int'(bus.stb), 1);
        to_cycle(3);
        chk("t1_stb_c3", int'(bus.stb), 1);
        to_cycle(4);
        chk("t1_stb_c4", int'(bus.stb), 0);
        chk("t1_id_c4", int'(bus.id), 2);
        to_cycle(5);
        chk("t1_busy_c5", int'(bus.busy), 1);
        to_cycle(6);
        chk("t1_busy_c6", int'(bus.busy), 0);
        to_cycle(10);
        chk("t1_queue", q.size(), 0);

        // 2: all four at once, back-to-back grants every 4 cycles
        do_reset();
        push(0, 2);
        push(1, 6);
        push(2, 10);
        push(3, 14);
        bus.req = 4'b1111;
        step();
        bus.req = '0;
        for (int t = 1; t <= 19; t++) begin
            to_cycle(t);
            chk("t2_busy", int'(bus.busy), (t >= 2 && t <= 17) ? 1 : 0);
        end
        chk("t2_queue", q.size(), 0);

        // 3: round-robin fairness after id 0
        do_reset();
        push(0, 2);
        push(1, 6);
        push(0, 10);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        to_cycle(3);
        bus.req = 4'b0011;
        step();
        bus.req = '0;
        to_cycle(16);
        chk("t3_busy", int'(bus.busy), 0);
        chk("t3_queue", q.size(), 0);

        // 4: overflow on requester 1 while id 0 is being served
        do_reset();
        push(0, 2);
        push(1, 6);
        bus.req = 4'b0011;
        step();
        bus.req = '0;
        for (int t = 1; t <= 10; t++) begin
            to_cycle(t);
            if (t == 3) bus.req = 4'b0010;
            if (t == 4) bus.req = '0;
            chk("t4_drop1", int'(bus.drop[1]), t == 4 ? 1 : 0);
        end
        to_cycle(14);
        chk("t4_queue", q.size(), 0);

        // 5: req[3] coincides with its own grant
        do_reset();
        push(3, 2);
        push(3, 6);
        bus.req = 4'b1000;
        step();
        chk("t5_pend_c1", int'(bus.pend), 8);
        step();
        bus.req = '0;
        chk("t5_drop_c2", int'(bus.drop), 0);
        chk("t5_pend_c2", int'(bus.pend), 8);
        to_cycle(12);
        chk("t5_pend_end", int'(bus.pend), 0);
        chk("t5_busy_end", int'(bus.busy), 0);
        chk("t5_queue", q.size(), 0);

        // 6: asynchronous reset in the middle of a pulse
        do_reset();
        push(0, 2);
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        to_cycle(2);
        chk("t6_stb_before", int'(bus.stb), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_stb_async", int'(bus.stb), 0);
        chk("t6_pend_async", int'(bus.pend), 0);
        chk("t6_busy_async", int'(bus.busy), 0);
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (bus.stb) seen++;
        end
        chk("t6_no_pulse", seen, 0);
        chk("t6_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stretch_sched.md
Name: stretch_sched

Overview:
- Shares one sync_stretch channel among N event requesters in the source clock domain.
- Latches single-cycle requests as sticky pending flags and grants them round-robin.
- Drives the stretcher input with a pulse of exactly STRETCH cycles, then holds it low for at least GAP cycles so the destination domain always sees separate pulses.
- Presents the granted requester index alongside the pulse.

Parameters:
- N, 4, number of requesters (2..16).
- STRETCH, 2, cycles stb is held high per grant (>=1).
- GAP, 2, minimum cycles stb is held low between grants (>=1).
- IDW, $clog2(N), width of id; derived localparam, not overridable.

Ports:
- clk  in  1  source-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester event strobe; 1 cycle high = 1 event.
- stb  out  1  stretched pulse to the sync_stretch input.
- id  out  IDW  index of the granted requester; stable while stb is high and through the following GAP phase.
- pend  out  N  pending-event flags.
- drop  out  N  1-cycle flag: an event was lost because that requester was already pending.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, stb=0, id=0, pend=0, drop=0, rr pointer=0, counter=0. Takes effect immediately, including mid-pulse. No pulse is emitted after release unless a new req arrives.
- Pending register update, per bit i at each edge:
  - pend[i] <= (pend[i] & ~clr[i]) | req[i], where clr[i] = grant of i this edge.
  - drop[i] <= req[i] & pend[i] & ~clr[i].
  - When req[i] coincides with a grant of i, the new event stays pending; no drop.
- Latency: req at cycle t sets pend at t+1. A grant from IDLE at cycle t+1 gives stb=1 at t+2.
- Arbitration: the winner is the first set pend bit at index >= ptr, wrapping modulo N. On grant, ptr <= winner+1, wrapping to 0 past N-1.
- FSM states and transitions:
  - IDLE: stb=0. If pend != 0, grant, load id, counter <= STRETCH-1, go HIGH, stb <= 1.
  - HIGH: stb=1. Counter decrements each cycle. At 0: stb <= 0, counter <= GAP-1, go LOW.
  - LOW: stb=0. Counter decrements each cycle. At 0: if pend != 0 (including req arriving this cycle, via the next-state pend value), grant directly, go HIGH, stb <= 1. Otherwise go IDLE.
- Timing results:
  - Back-to-back grant period is STRETCH+GAP cycles.
  - An isolated grant occupies STRETCH high cycles plus GAP low cycles, then 1 IDLE cycle minimum before the next grant.
- stb and id are registered outputs; there are no combinational paths from req to any output.
- Counter width is $clog2(max(STRETCH,GAP))+1. No wrap is possible because it is reloaded on every state entry.

Decomposition:
- Shared header stretch_defs: state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) and the clog2 helper. The encoding 2'd3 is unreachable and decodes to IDLE.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: N-bit request vector, ptr.
  - Outputs: valid, winner index.
- stretch_sched holds all state; sync_stretch is instantiated by the parent, not here.

Test Plan (N=4, STRETCH=2, GAP=2, req edge at end of cycle 0):
1. req=4'b0100 for 1 cycle -> pend[2]=1 at cycle 1; stb=1 in cycles 2-3 with id=2; stb=0 in cycles 4-5; busy=0 from cycle 6; pend=0 from cycle 2.
2. req=4'b1111 for 1 cycle -> stb rising edges at cycles 2, 6, 10, 14 with id 0, 1, 2, 3; busy continuous from cycle 2 to cycle 17.
3. Round-robin fairness: after id=0 is granted, req=4'b0011 -> next grants are id=1 then id=0, not 0 first.
4. Overflow: req[1] at cycle 0 and again at cycle 3 while stb is serving another requester -> drop[1]=1 for exactly 1 cycle (cycle 4); exactly one pulse with id=1.
5. Coincident set/clear: req[3] asserted in the same cycle pend[3] is granted -> no drop; pend[3] stays 1; a second id=3 pulse follows STRETCH+GAP cycles later.
6. Reset mid-pulse: reset_n=0 during HIGH -> stb=0, pend=0, busy=0 with no clock edge; after release with req=0 for 20 cycles, stb stays 0.
